// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and the buffered writeback entry type for wb_port_arbiter.
package wb_port_arbiter_pkg;

  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  localparam int ROB_ADDR_WIDTH       = 5;
  localparam int DISPATCH_WIDTH       = 2;
  localparam int WB_DATA_WIDTH        = 32;

  typedef struct packed {
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [WB_DATA_WIDTH-1:0]        data;
    logic [ROB_ADDR_WIDTH-1:0]       rob_addr;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Source-side and writeback-side bundle of wb_port_arbiter, plus debug taps
// exposing the round-robin pointer and per-source buffer occupancy.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int WB_PORTS   = DISPATCH_WIDTH,
  parameter int BUF_DEPTH  = 2,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int RR_W  = $clog2(NUM_SRC);

  // Handshake: source s transfers a result on a cycle where src_valid[s] and
  // src_ready[s] are both high at the clock edge; a source that sees valid
  // without ready must hold the same result. Writeback ports have no ready:
  // a port with wb_valid high is consumed that cycle.
  logic [NUM_SRC-1:0]                      src_valid;
  logic [NUM_SRC-1:0]                      src_ready;
  logic [NUM_SRC*PHYS_REGS_ADDR_WIDTH-1:0] src_phys_rd;
  logic [NUM_SRC*DATA_WIDTH-1:0]           src_data;
  logic [NUM_SRC*ROB_ADDR_WIDTH-1:0]       src_rob_addr;

  logic [WB_PORTS-1:0]                      wb_valid;
  logic [WB_PORTS*PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd;
  logic [WB_PORTS*DATA_WIDTH-1:0]           wb_data;
  logic [WB_PORTS*ROB_ADDR_WIDTH-1:0]       wb_rob_addr;

  logic [RR_W-1:0]          dbg_rr_ptr;
  logic [NUM_SRC*CNT_W-1:0] dbg_count;

  modport slave (
    input  src_valid, src_phys_rd, src_data, src_rob_addr,
    output src_ready, wb_valid, wb_phys_rd, wb_data, wb_rob_addr,
    output dbg_rr_ptr, dbg_count
  );

  modport master (
    output src_valid, src_phys_rd, src_data, src_rob_addr,
    input  src_ready, wb_valid, wb_phys_rd, wb_data, wb_rob_addr,
    input  dbg_rr_ptr, dbg_count
  );

endinterface

// File: rtl/wb_port_arbiter_src_fifo.sv
// wb_src_fifo: per-source result buffer of DEPTH wb_entry_t (DEPTH a power of
// two, so head/tail wrap naturally). The caller never pushes when full or pops when empty.
module wb_src_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Storage needs no reset: count_q alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[head_q];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares WB_PORTS writeback ports among NUM_SRC buffered result sources with a
// round-robin scan. Optional macro WB_ARB_BYPASS_EN lets an empty source win a port the same cycle.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int WB_PORTS   = DISPATCH_WIDTH,
  parameter int BUF_DEPTH  = 2,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);
  localparam int PW     = PHYS_REGS_ADDR_WIDTH;
  localparam int RW     = ROB_ADDR_WIDTH;
  localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
  localparam int RR_W   = $clog2(NUM_SRC);
  localparam int RANK_W = RR_W + 1;

  wb_entry_t                     src_entry [NUM_SRC];
  wb_entry_t                     head      [NUM_SRC];
  logic [CNT_W-1:0]              count     [NUM_SRC];
  logic [NUM_SRC-1:0]            src_ready, push, pop, cand, gnt;
  logic [RR_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [WB_PORTS-1:0]           port_vld;
  logic [WB_PORTS-1:0][RR_W-1:0] port_sel;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign src_entry[s].phys_rd  = bus.src_phys_rd[s*PW +: PW];
    assign src_entry[s].data     = bus.src_data[s*DATA_WIDTH +: DATA_WIDTH];
    assign src_entry[s].rob_addr = bus.src_rob_addr[s*RW +: RW];

    // Ready looks only at the registered count; a pop this cycle frees space next cycle.
    assign src_ready[s] = !rst && (count[s] < CNT_W'(BUF_DEPTH));
`ifdef WB_ARB_BYPASS_EN
    assign cand[s] = !rst && ((count[s] != '0) || bus.src_valid[s]);
    assign push[s] = bus.src_valid[s] && src_ready[s] && !(gnt[s] && (count[s] == '0));
`else
    assign cand[s] = !rst && (count[s] != '0);
    assign push[s] = bus.src_valid[s] && src_ready[s];
`endif
    assign pop[s] = gnt[s] && (count[s] != '0);
    assign bus.dbg_count[s*CNT_W +: CNT_W] = count[s];

    wb_src_fifo #(
      .DEPTH(BUF_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[s]),
      .push_entry (src_entry[s]),
      .pop        (pop[s]),
      .count      (count[s]),
      .head       (head[s])
    );
  end

  assign bus.src_ready = src_ready;

  // Scan from rr_ptr; the candidate of rank k (k-th found) takes port k.
  always_comb begin
    logic [RR_W-1:0]   idx;
    logic [RANK_W-1:0] rank;
    logic [RR_W-1:0]   last;
    logic              any;
    port_vld = '0;
    port_sel = '0;
    gnt      = '0;
    idx      = '0;
    rank     = '0;
    last     = rr_ptr_q;
    any      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = rr_ptr_q + RR_W'(i);
      for (int p = 0; p < WB_PORTS; p++) begin
        if (cand[idx] && (rank == RANK_W'(p))) begin
          port_vld[p] = 1'b1;
          port_sel[p] = idx;
          gnt[idx]    = 1'b1;
          last        = idx;
          any         = 1'b1;
        end
      end
      rank = rank + RANK_W'(cand[idx]);
    end
    rr_ptr_d = any ? (last + RR_W'(1)) : rr_ptr_q;
  end

  always_comb begin
    wb_entry_t ent;
    ent             = '0;
    bus.wb_valid    = port_vld;
    bus.wb_phys_rd  = '0;
    bus.wb_data     = '0;
    bus.wb_rob_addr = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      ent = '0;
      if (port_vld[p]) begin
`ifdef WB_ARB_BYPASS_EN
        ent = (count[port_sel[p]] == '0) ? src_entry[port_sel[p]] : head[port_sel[p]];
`else
        ent = head[port_sel[p]];
`endif
      end
      bus.wb_phys_rd[p*PW +: PW]                 = ent.phys_rd;
      bus.wb_data[p*DATA_WIDTH +: DATA_WIDTH]    = ent.data;
      bus.wb_rob_addr[p*RW +: RW]                = ent.rob_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed cycle table, hand sequences and random
// streaming, all checked against a queue-based reference model.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int NS = 4;
  localparam int WP = 2;
  localparam int BD = 2;
  localparam int DW = WB_DATA_WIDTH;
  localparam int PW = PHYS_REGS_ADDR_WIDTH;
  localparam int RW = ROB_ADDR_WIDTH;
  localparam int EW = $bits(wb_entry_t);
  localparam int CW = $clog2(BD) + 1;
  localparam int SW = $clog2(NS);
  localparam logic [PW-1:0] SRC0_TAG = PW'(40);
  localparam wb_entry_t ZE = '0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NUM_SRC(NS), .WB_PORTS(WP), .BUF_DEPTH(BD)) bus ();

  wb_port_arbiter #(
    .NUM_SRC(NS), .WB_PORTS(WP), .BUF_DEPTH(BD), .DATA_WIDTH(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [EW-1:0] exp_q [NS][$];
  logic [SW-1:0] model_rr;
  logic          cur_rst;
  logic [NS-1:0] cur_v;
  wb_entry_t     cur_e [NS];
  logic [NS-1:0] acc;
  logic [DW-1:0] src0_q [$];
  bit            saw_nr0;
  logic [EW-1:0] pend [NS][$];
  bit            pres [NS];

  typedef struct packed {
    logic                  r;
    logic [NS-1:0]         v;
    wb_entry_t [NS-1:0]    e;
    logic [WP-1:0]         xv;
    wb_entry_t [WP-1:0]    xp;
    logic [NS-1:0]         xr;
    logic [SW-1:0]         xrr;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic wb_entry_t mk(input logic [PW-1:0] ph, input logic [DW-1:0] d,
                                   input logic [RW-1:0] rb);
    wb_entry_t e;
    e.phys_rd  = ph;
    e.data     = d;
    e.rob_addr = rb;
    return e;
  endfunction

  function automatic wb_entry_t port_ent(input int p);
    wb_entry_t e;
    e.phys_rd  = bus.wb_phys_rd[p*PW +: PW];
    e.data     = bus.wb_data[p*DW +: DW];
    e.rob_addr = bus.wb_rob_addr[p*RW +: RW];
    return e;
  endfunction

  function automatic vec_t row(input logic r, input logic [3:0] v,
                               input wb_entry_t e0, e1, e2, e3,
                               input logic [1:0] xv, input wb_entry_t p0, p1,
                               input logic [3:0] xr, input logic [1:0] xrr);
    vec_t t;
    t.r = r; t.v = v;
    t.e[0] = e0; t.e[1] = e1; t.e[2] = e2; t.e[3] = e3;
    t.xv = xv; t.xp[0] = p0; t.xp[1] = p1;
    t.xr = xr; t.xrr = xrr;
    return t;
  endfunction

  // ---------------- driver ----------------
  task automatic drive();
    rst           = cur_rst;
    bus.src_valid = cur_v;
    for (int s = 0; s < NS; s++) begin
      bus.src_phys_rd[s*PW +: PW]  = cur_e[s].phys_rd;
      bus.src_data[s*DW +: DW]     = cur_e[s].data;
      bus.src_rob_addr[s*RW +: RW] = cur_e[s].rob_addr;
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Expected state lives in per-source queues; grants come from walking the
  // sources starting at the model pointer and handing out ports in order.
  task automatic model_cycle();
    logic [NS-1:0]    x_rdy;
    logic [WP-1:0]    x_v;
    logic [NS*CW-1:0] x_cnt;
    logic [NS-1:0]    popm, bypm;
    logic [SW-1:0]    s, last;
    wb_entry_t        gq [$];
    wb_entry_t        act;
    popm = '0; bypm = '0; last = model_rr; acc = '0;
    for (int i = 0; i < NS; i++) begin
      x_rdy[i]          = !cur_rst && (exp_q[i].size() < BD);
      x_cnt[i*CW +: CW] = CW'(exp_q[i].size());
    end
    for (int i = 0; i < NS; i++) begin
      s = model_rr + SW'(i);
      if (!cur_rst && gq.size() < WP) begin
        if (exp_q[s].size() > 0) begin
          gq.push_back(exp_q[s][0]); popm[s] = 1'b1; last = s;
        end
`ifdef WB_ARB_BYPASS_EN
        else if (cur_v[s]) begin
          gq.push_back(cur_e[s]); bypm[s] = 1'b1; last = s;
        end
`endif
      end
    end
    for (int p = 0; p < WP; p++) x_v[p] = (p < gq.size());

    check("src_ready", bus.src_ready, x_rdy);
    check("wb_valid", bus.wb_valid, x_v);
    for (int p = 0; p < WP; p++)
      check($sformatf("wb_port%0d", p), port_ent(p), (p < gq.size()) ? gq[p] : ZE);
    check("rr_ptr", bus.dbg_rr_ptr, model_rr);
    check("buf_count", bus.dbg_count, x_cnt);

    for (int p = 0; p < WP; p++) begin
      act = port_ent(p);
      if (bus.wb_valid[p] === 1'b1 && act.phys_rd == SRC0_TAG)
        check("src0_order", act.data, (src0_q.size() > 0) ? src0_q.pop_front() : 32'hBAD0BAD0);
    end

    if (cur_rst) begin
      for (int i = 0; i < NS; i++) exp_q[i].delete();
      model_rr = '0;
    end else begin
      for (int i = 0; i < NS; i++) if (popm[i]) void'(exp_q[i].pop_front());
      for (int i = 0; i < NS; i++) begin
        acc[i] = cur_v[i] && x_rdy[i];
        if (acc[i] && !bypm[i]) exp_q[i].push_back(cur_e[i]);
      end
      if (gq.size() > 0) model_rr = last + SW'(1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic idle(input int n);
    cur_rst = 1'b0; cur_v = '0;
    for (int s = 0; s < NS; s++) cur_e[s] = ZE;
    repeat (n) step();
  endtask

  task automatic do_reset();
    cur_rst = 1'b1; cur_v = '0;
    for (int s = 0; s < NS; s++) cur_e[s] = ZE;
    step();
    cur_rst = 1'b0;
  endtask

  function automatic bit busy();
    for (int s = 0; s < NS; s++) if (pend[s].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Each source presents its pending head and holds it until accepted.
  task automatic stream(input int max_cyc, input int gate_pct, input int rst_pct, output int used);
    used = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (!busy()) break;
      cur_rst = ($urandom_range(0, 99) < rst_pct);
      for (int s = 0; s < NS; s++) begin
        if (!pres[s] && pend[s].size() > 0 && $urandom_range(0, 99) < gate_pct) pres[s] = 1'b1;
        cur_v[s] = pres[s];
        cur_e[s] = pres[s] ? wb_entry_t'(pend[s][0]) : ZE;
      end
      step();
      used++;
      if (!cur_rst && bus.src_ready[0] === 1'b0) saw_nr0 = 1'b1;
      for (int s = 0; s < NS; s++) begin
        if (acc[s]) begin
          void'(pend[s].pop_front());
          pres[s] = 1'b0;
        end
      end
    end
    check("stream_drained", busy(), 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    wb_entry_t e1, a [4], b [4], c [4];
    int used;
    cur_rst = 1'b1; cur_v = '0; model_rr = '0;
    for (int s = 0; s < NS; s++) begin cur_e[s] = ZE; pres[s] = 1'b0; end
    drive();

    e1 = mk(5, 32'hDEAD, 3);
    for (int s = 0; s < 4; s++) begin
      a[s] = mk(PW'(8 + s),  32'hA000 + s, RW'(s));
      b[s] = mk(PW'(16 + s), 32'hB000 + s, RW'(4 + s));
      c[s] = mk(PW'(24 + s), 32'hC000 + s, RW'(8 + s));
    end
    tbl[0]  = row(1, 4'b0000, ZE, ZE, ZE, ZE,       2'b00, ZE,   ZE,   4'h0, 0);
    tbl[1]  = row(0, 4'b0100, ZE, ZE, e1, ZE,       2'b00, ZE,   ZE,   4'hF, 0);
    tbl[2]  = row(0, 4'b0000, ZE, ZE, ZE, ZE,       2'b01, e1,   ZE,   4'hF, 0);
    tbl[3]  = row(0, 4'b0000, ZE, ZE, ZE, ZE,       2'b00, ZE,   ZE,   4'hF, 3);
    tbl[4]  = row(1, 4'b0000, ZE, ZE, ZE, ZE,       2'b00, ZE,   ZE,   4'h0, 3);
    tbl[5]  = row(0, 4'b1111, a[0], a[1], a[2], a[3], 2'b00, ZE,   ZE,   4'hF, 0);
    tbl[6]  = row(0, 4'b0000, ZE, ZE, ZE, ZE,       2'b11, a[0], a[1], 4'hF, 0);
    tbl[7]  = row(0, 4'b0000, ZE, ZE, ZE, ZE,       2'b11, a[2], a[3], 4'hF, 2);
    tbl[8]  = row(0, 4'b0000, ZE, ZE, ZE, ZE,       2'b00, ZE,   ZE,   4'hF, 0);
    tbl[9]  = row(0, 4'b1111, b[0], b[1], b[2], b[3], 2'b00, ZE,   ZE,   4'hF, 0);
    tbl[10] = row(0, 4'b1111, c[0], c[1], c[2], c[3], 2'b11, b[0], b[1], 4'hF, 0);
    tbl[11] = row(1, 4'b0000, ZE, ZE, ZE, ZE,       2'b00, ZE,   ZE,   4'h0, 2);
    tbl[12] = row(0, 4'b0000, ZE, ZE, ZE, ZE,       2'b00, ZE,   ZE,   4'hF, 0);
    tbl[13] = row(0, 4'b0000, ZE, ZE, ZE, ZE,       2'b00, ZE,   ZE,   4'hF, 0);

    do_reset();
    do_reset();

`ifndef WB_ARB_BYPASS_EN
    for (int r = 0; r < 14; r++) begin
      cur_rst = tbl[r].r;
      cur_v   = tbl[r].v;
      for (int s = 0; s < NS; s++) cur_e[s] = tbl[r].e[s];
      step();
      check($sformatf("row%0d_wb_valid", r), bus.wb_valid, tbl[r].xv);
      check($sformatf("row%0d_port0", r), port_ent(0), tbl[r].xp[0]);
      check($sformatf("row%0d_port1", r), port_ent(1), tbl[r].xp[1]);
      check($sformatf("row%0d_ready", r), bus.src_ready, tbl[r].xr);
      check($sformatf("row%0d_rr", r), bus.dbg_rr_ptr, tbl[r].xrr);
      if (r == 12) check("post_reset_counts", bus.dbg_count, '0);
    end
`else
    do_reset();
    idle(1);
    cur_v = 4'b1000; cur_e[3] = mk(3, 32'h77, 1);
    step();
    check("byp_wb_valid", bus.wb_valid, 2'b01);
    check("byp_data", port_ent(0).data, 32'h77);
    cur_v = '0; cur_e[3] = ZE;
    for (int i = 0; i < 3; i++) begin
      step();
      check("byp_no_dup", bus.wb_valid, 2'b00);
    end
`endif

    // src1 streams alone: one acceptance per cycle
    do_reset();
    for (int i = 0; i < 6; i++) pend[1].push_back(mk(PW'(20 + i), 32'h1000 + i, RW'(i)));
    stream(20, 100, 0, used);
    check("src1_stream_cycles", used, 6);
    idle(3);

    // src0 pushes A,B,C against three other streaming sources
    do_reset();
    saw_nr0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[0].push_back(mk(SRC0_TAG, DW'(32'hA + i), RW'(i)));
      src0_q.push_back(DW'(32'hA + i));
      for (int s = 1; s < NS; s++)
        pend[s].push_back(mk(PW'(30 + s), 32'h2000 + s * 16 + i, RW'(i)));
    end
    stream(40, 100, 0, used);
    idle(8);
`ifndef WB_ARB_BYPASS_EN
    check("src0_ready_dropped", saw_nr0, 1'b1);
`endif
    check("src0_all_seen", src0_q.size(), 0);

    // random streaming with occasional reset
    do_reset();
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 30; i++)
        pend[s].push_back(mk(PW'($urandom_range(0, 39)), $urandom, RW'($urandom_range(0, 31))));
    stream(800, 60, 2, used);
    idle(8);
    for (int s = 0; s < NS; s++) pres[s] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
